// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory program loader.
// Optional build macro: IMEM_LOADER_CSUM_EN (see imem_loader.sv).
package imem_loader_pkg;

  localparam int ADDR_W_DEF    = 12;
  localparam int DATA_W_DEF    = 32;
  localparam int RUN_DELAY_DEF = 2;
  localparam int RUN_DELAY_MAX = 15;
  localparam int CNT_W         = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WAIT = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

endpackage

// File: rtl/imem_loader.sv
// Program loader: streams instruction words into consecutive imem word
// addresses, then releases the core via core_run after RUN_DELAY cycles.
// Optional build macro IMEM_LOADER_CSUM_EN adds a running word checksum
// (csum) compared against csum_exp on the final word; a mismatch goes to ERR.
//
// Handshake: a word transfers on a rising edge where s_valid && s_ready.
// s_ready is decoded from the state register only (high exactly in LOAD) and
// never depends on s_valid; the producer holds s_valid/s_data/s_last stable
// until the transfer. The imem write is registered one cycle after transfer.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RUN_DELAY = RUN_DELAY_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              imem_write,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              core_run,
  output logic              err_overflow,
  output logic [ADDR_W:0]   word_count,
`ifdef IMEM_LOADER_CSUM_EN
  output logic [DATA_W-1:0] csum,
  input  logic [DATA_W-1:0] csum_exp,
  output logic              err_csum,
`endif
  output state_t            dbg_state
);

  localparam logic [ADDR_W-1:0] PTR_MAX   = '1;
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [CNT_W-1:0]  DELAY_VAL = CNT_W'(RUN_DELAY);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]    dly_q, dly_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_ovf_q, err_ovf_d;
  logic                run_q, run_d;
  logic                done_q, done_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic                err_sum_q, err_sum_d;
  logic                accept;
  logic                csum_bad;

  assign accept = s_valid && (state_q == ST_LOAD);

`ifdef IMEM_LOADER_CSUM_EN
  // Final-word check uses the sum including the word being accepted.
  assign csum_bad = ((sum_q + s_data) != csum_exp);
`else
  assign csum_bad = 1'b0;
`endif

  // Next-state, pointer, counters and registered imem write request.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    dly_d     = dly_q;
    count_d   = count_q;
    err_ovf_d = err_ovf_q;
    run_d     = run_q;
    done_d    = 1'b0;
    wr_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    sum_d     = sum_q;
    err_sum_d = err_sum_q;
    case (state_q)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (start) begin
          state_d   = ST_LOAD;
          ptr_d     = base_addr;
          count_d   = '0;
          err_ovf_d = 1'b0;
          err_sum_d = 1'b0;
          sum_d     = '0;
          run_d     = 1'b0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          wr_d    = 1'b1;
          waddr_d = ptr_q;
          wdata_d = s_data;
          ptr_d   = ptr_q + PTR_ONE;
          count_d = count_q + CNT_ONE;
          sum_d   = sum_q + s_data;
          if (s_last) begin
            if (csum_bad) begin
              state_d   = ST_ERR;
              err_sum_d = 1'b1;
            end else begin
              state_d = ST_WAIT;
              dly_d   = DELAY_VAL;
            end
          end else if (ptr_q == PTR_MAX) begin
            // Word at the top address is still written; there is no room
            // for the next one.
            state_d   = ST_ERR;
            err_ovf_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (dly_q <= CNT_W'(1)) begin
          state_d = ST_RUN;
          dly_d   = '0;
          run_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          dly_d = dly_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any session at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      dly_q     <= '0;
      count_q   <= '0;
      err_ovf_q <= 1'b0;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
      wr_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      sum_q     <= '0;
      err_sum_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      dly_q     <= dly_d;
      count_q   <= count_d;
      err_ovf_q <= err_ovf_d;
      run_q     <= run_d;
      done_q    <= done_d;
      wr_q      <= wr_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      sum_q     <= sum_d;
      err_sum_q <= err_sum_d;
    end
  end

  assign s_ready      = (state_q == ST_LOAD);
  assign busy         = (state_q == ST_LOAD) || (state_q == ST_WAIT);
  assign imem_write   = wr_q;
  assign imem_addr    = waddr_q;
  assign imem_wdata   = wdata_q;
  assign done         = done_q;
  assign core_run     = run_q;
  assign err_overflow = err_ovf_q;
  assign word_count   = count_q;
  assign dbg_state    = state_q;
`ifdef IMEM_LOADER_CSUM_EN
  assign csum     = sum_q;
  assign err_csum = err_sum_q;
`else
  // Checksum state is only observable with the option enabled.
  logic unused_sum;
  assign unused_sum = ^{sum_q, err_sum_q, csum_bad};
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: back-to-back load, gapped stream,
// address overflow, restart/ignored start, edge cases, reset mid-load and
// (with IMEM_LOADER_CSUM_EN) the checksum path.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          imem_write;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic          busy, done, core_run, err_overflow;
  logic [AW:0]   word_count;
  state_t        dbg_state;
`ifdef IMEM_LOADER_CSUM_EN
  logic [DW-1:0] csum;
  logic [DW-1:0] csum_exp = '0;
  logic          err_csum;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int            wr_cyc_q[$];

  imem_loader #(.ADDR_W(AW), .DATA_W(DW), .RUN_DELAY(2)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .imem_write(imem_write), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .core_run(core_run),
    .err_overflow(err_overflow), .word_count(word_count),
`ifdef IMEM_LOADER_CSUM_EN
    .csum(csum), .csum_exp(csum_exp), .err_csum(err_csum),
`endif
    .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Write log: records every imem write seen mid-cycle with its cycle index.
  always @(negedge clk) begin
    cyc++;
    if (imem_write === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
      wr_cyc_q.push_back(cyc);
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic do_start(input logic [AW-1:0] base);
    start = 1'b1;
    base_addr = base;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_word(input logic [DW-1:0] d, input logic last);
    s_valid = 1'b1;
    s_data = d;
    s_last = last;
    tick();
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_run();
    for (int i = 0; i < 20; i++) begin
      if (core_run === 1'b1) break;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({imem_write, busy, done, core_run, err_overflow, s_ready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000000",
               {imem_write, busy, done, core_run, err_overflow, s_ready});
    end
    checks++;
    if (word_count !== '0 || imem_addr !== '0 || imem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_data got cnt=%h addr=%h data=%h exp 0", word_count, imem_addr, imem_wdata);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_IDLE);
    end
    #3 reset = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] words [3];
    words[0] = 32'h00500093;
    words[1] = 32'h00100113;
    words[2] = 32'h002081B3;
    clear_log();
    do_start(12'h000);
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b1 || word_count !== '0) begin
      errors++;
      $display("FAIL b2b_load_entry got rdy=%b busy=%b cnt=%0d exp 1 1 0", s_ready, busy, word_count);
    end
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data = words[i];
      s_last = (i == 2);
      tick();
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    checks++;
    if (imem_write !== 1'b1 || imem_addr !== 12'h002 || imem_wdata !== 32'h002081B3) begin
      errors++;
      $display("FAIL b2b_last_write got w=%b a=%h d=%h exp 1 002 002081b3", imem_write, imem_addr, imem_wdata);
    end
    checks++;
    if (word_count !== 13'd3 || dbg_state !== ST_WAIT) begin
      errors++;
      $display("FAIL b2b_count got cnt=%0d st=%0d exp 3 %0d", word_count, dbg_state, ST_WAIT);
    end
    tick();
    checks++;
    if (core_run !== 1'b0 || done !== 1'b0 || imem_write !== 1'b0) begin
      errors++;
      $display("FAIL b2b_delay1 got run=%b done=%b w=%b exp 0 0 0", core_run, done, imem_write);
    end
    tick();
    checks++;
    if (core_run !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || dbg_state !== ST_RUN) begin
      errors++;
      $display("FAIL b2b_run_rise got run=%b done=%b busy=%b st=%0d exp 1 1 0 %0d",
               core_run, done, busy, dbg_state, ST_RUN);
    end
    tick();
    checks++;
    if (core_run !== 1'b1 || done !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_pulse got run=%b done=%b rdy=%b exp 1 0 0", core_run, done, s_ready);
    end
    checks++;
    if (wr_addr_q.size() != 3) begin
      errors++;
      $display("FAIL b2b_nwrites got %0d exp 3", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== words[i] ||
            (i > 0 && wr_cyc_q[i] != wr_cyc_q[i-1] + 1)) begin
          errors++;
          $display("FAIL b2b_write%0d got a=%h d=%h exp a=%h d=%h consecutive",
                   i, wr_addr_q[i], wr_data_q[i], AW'(i), words[i]);
        end
      end
    end
  endtask

  task automatic test_gaps();
    logic [DW-1:0] words [3];
    logic [4:0]    pat;
    int            k;
    words[0] = 32'h00500093;
    words[1] = 32'h00100113;
    words[2] = 32'h002081B3;
    pat = 5'b10101;
    k = 0;
    clear_log();
    do_start(12'h000);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (s_ready !== 1'b1) begin
        errors++;
        $display("FAIL gap_ready%0d got %b exp 1", i, s_ready);
      end
      s_valid = pat[i];
      s_data = pat[i] ? words[k] : 32'hDEADBEEF;
      s_last = pat[i] && (k == 2);
      tick();
      if (pat[i]) k++;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    wait_run();
    checks++;
    if (core_run !== 1'b1 || word_count !== 13'd3) begin
      errors++;
      $display("FAIL gap_run got run=%b cnt=%0d exp 1 3", core_run, word_count);
    end
    checks++;
    if (wr_addr_q.size() != 3) begin
      errors++;
      $display("FAIL gap_nwrites got %0d exp 3", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== words[i] ||
            (i > 0 && wr_cyc_q[i] != wr_cyc_q[i-1] + 2)) begin
          errors++;
          $display("FAIL gap_write%0d got a=%h d=%h exp a=%h d=%h spaced by 2",
                   i, wr_addr_q[i], wr_data_q[i], AW'(i), words[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    clear_log();
    do_start(12'hFFE);
    drive_word(32'h11111111, 1'b0);
    drive_word(32'h22222222, 1'b0);
    checks++;
    if (dbg_state !== ST_ERR || err_overflow !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL ovf_enter got st=%0d err=%b rdy=%b exp %0d 1 0", dbg_state, err_overflow, s_ready, ST_ERR);
    end
    checks++;
    if (imem_write !== 1'b1 || imem_addr !== 12'hFFF || imem_wdata !== 32'h22222222) begin
      errors++;
      $display("FAIL ovf_top_write got w=%b a=%h d=%h exp 1 fff 22222222", imem_write, imem_addr, imem_wdata);
    end
    s_valid = 1'b1;
    s_data = 32'h33333333;
    s_last = 1'b1;
    tick();
    tick();
    tick();
    s_valid = 1'b0;
    s_last = 1'b0;
    checks++;
    if (wr_addr_q.size() != 2) begin
      errors++;
      $display("FAIL ovf_nwrites got %0d exp 2", wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 12'hFFE || wr_addr_q[1] !== 12'hFFF) begin
        errors++;
        $display("FAIL ovf_addrs got %h %h exp ffe fff", wr_addr_q[0], wr_addr_q[1]);
      end
    end
    checks++;
    if (core_run !== 1'b0 || busy !== 1'b0 || err_overflow !== 1'b1 || word_count !== 13'd2) begin
      errors++;
      $display("FAIL ovf_hold got run=%b busy=%b err=%b cnt=%0d exp 0 0 1 2",
               core_run, busy, err_overflow, word_count);
    end
  endtask

  task automatic test_restart();
    // From ERR: accepted start clears the sticky error.
    clear_log();
    do_start(12'h100);
    checks++;
    if (err_overflow !== 1'b0 || word_count !== '0 || dbg_state !== ST_LOAD) begin
      errors++;
      $display("FAIL rst_from_err got err=%b cnt=%0d st=%0d exp 0 0 %0d", err_overflow, word_count, dbg_state, ST_LOAD);
    end
    drive_word(32'hAAAA0001, 1'b0);
    // Start during LOAD is ignored; the word still lands at the next address.
    start = 1'b1;
    base_addr = 12'h200;
    drive_word(32'hAAAA0002, 1'b1);
    start = 1'b0;
    checks++;
    if (dbg_state !== ST_WAIT || imem_addr !== 12'h101 || word_count !== 13'd2) begin
      errors++;
      $display("FAIL load_start_ignored got st=%0d a=%h cnt=%0d exp %0d 101 2", dbg_state, imem_addr, word_count, ST_WAIT);
    end
    wait_run();
    checks++;
    if (core_run !== 1'b1) begin
      errors++;
      $display("FAIL restart_run1 got %b exp 1", core_run);
    end
    // From RUN: core_run drops on the start edge; single-word program.
    do_start(12'h300);
    checks++;
    if (core_run !== 1'b0 || word_count !== '0 || dbg_state !== ST_LOAD) begin
      errors++;
      $display("FAIL run_reload got run=%b cnt=%0d st=%0d exp 0 0 %0d", core_run, word_count, dbg_state, ST_LOAD);
    end
    drive_word(32'h0000CAFE, 1'b1);
    checks++;
    if (dbg_state !== ST_WAIT || word_count !== 13'd1 || imem_addr !== 12'h300 || imem_write !== 1'b1) begin
      errors++;
      $display("FAIL single_word got st=%0d cnt=%0d a=%h w=%b exp %0d 1 300 1",
               dbg_state, word_count, imem_addr, imem_write, ST_WAIT);
    end
    wait_run();
    // Last word at the top address is legal.
    do_start(12'hFFF);
    drive_word(32'h0000BEEF, 1'b1);
    checks++;
    if (dbg_state !== ST_WAIT || err_overflow !== 1'b0 || imem_addr !== 12'hFFF) begin
      errors++;
      $display("FAIL top_last got st=%0d err=%b a=%h exp %0d 0 fff", dbg_state, err_overflow, imem_addr, ST_WAIT);
    end
    wait_run();
    checks++;
    if (core_run !== 1'b1 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL top_last_run got run=%b err=%b exp 1 0", core_run, err_overflow);
    end
  endtask

  task automatic test_reset_mid_load();
    do_start(12'h000);
    drive_word(32'h00000001, 1'b0);
    drive_word(32'h00000002, 1'b0);
    s_valid = 1'b1;
    s_data = 32'h00000003;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({imem_write, busy, done, core_run, err_overflow, s_ready} !== 6'b0 ||
        word_count !== '0 || imem_addr !== '0 || imem_wdata !== '0) begin
      errors++;
      $display("FAIL async_reset got flags=%b cnt=%0d a=%h d=%h exp all 0",
               {imem_write, busy, done, core_run, err_overflow, s_ready}, word_count, imem_addr, imem_wdata);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL async_reset_state got %0d exp %0d", dbg_state, ST_IDLE);
    end
    clear_log();
    tick();
    tick();
    #3 reset = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    s_valid = 1'b0;
    checks++;
    if (wr_addr_q.size() != 0 || dbg_state !== ST_IDLE || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle got writes=%0d st=%0d rdy=%b exp 0 %0d 0", wr_addr_q.size(), dbg_state, s_ready, ST_IDLE);
    end
  endtask

`ifdef IMEM_LOADER_CSUM_EN
  task automatic test_csum();
    csum_exp = 32'd6;
    do_start(12'h010);
    checks++;
    if (csum !== '0) begin
      errors++;
      $display("FAIL csum_clear got %h exp 0", csum);
    end
    drive_word(32'd1, 1'b0);
    drive_word(32'd2, 1'b0);
    drive_word(32'd3, 1'b1);
    wait_run();
    checks++;
    if (dbg_state !== ST_RUN || csum !== 32'd6 || err_csum !== 1'b0) begin
      errors++;
      $display("FAIL csum_ok got st=%0d csum=%0d err=%b exp %0d 6 0", dbg_state, csum, err_csum, ST_RUN);
    end
    csum_exp = 32'd7;
    do_start(12'h010);
    drive_word(32'd1, 1'b0);
    drive_word(32'd2, 1'b0);
    drive_word(32'd3, 1'b1);
    tick();
    tick();
    tick();
    checks++;
    if (dbg_state !== ST_ERR || err_csum !== 1'b1 || core_run !== 1'b0) begin
      errors++;
      $display("FAIL csum_bad got st=%0d err=%b run=%b exp %0d 1 0", dbg_state, err_csum, core_run, ST_ERR);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_overflow();
    test_restart();
    test_reset_mid_load();
`ifdef IMEM_LOADER_CSUM_EN
    test_csum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
